mem_bus_arbiter: RTL and testbench

//  Shares the single Avalon-style memory slave port (address/read/write/waitrequest/byteenable) between two masters:
//  M0 = mips_cpu_bus, M1 = loader/debug DMA. One transfer in flight at a time; a grant holds until the slave completes.

---
 rtl/mips_bus_pkg.sv | 30 +++
 rtl/mem_bus_arbiter_arb_policy.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin contention instead of fixed priority.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  function automatic logic [1:0] grant_of(input arb_state_t st);
    case (st)
      OWN0:    return GRANT_M0;
      OWN1:    return GRANT_M1;
      default: return GRANT_NONE;
    endcase
  endfunction

  function automatic arb_state_t own_state(input logic owner);
    return (owner == OWNER_M1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_policy.sv
// Combinational winner selection between the two bus masters.
// Build option: ARB_ROUND_ROBIN_EN (round-robin on contention), otherwise fixed priority with M1 anti-starvation.
module arb_policy
  import mips_bus_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int HOLD_W   = $clog2(HOLD_MAX + 1)
) (
  input  logic              req0,
  input  logic              req1,
  input  logic              last_owner,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic              winner
);

  logic contended_pick;

`ifdef ARB_ROUND_ROBIN_EN
  assign contended_pick = ~last_owner;

  logic unused_hold;
  assign unused_hold = ^hold_cnt;
`else
  // M0 normally wins; M1 breaks through once M0 has had HOLD_MAX grants in a row.
  assign contended_pick = (hold_cnt == HOLD_W'(HOLD_MAX)) ? OWNER_M1 : OWNER_M0;

  logic unused_last;
  assign unused_last = last_owner;
`endif

  always_comb begin
    winner = OWNER_M0;
    if (req0 && req1) begin
      winner = contended_pick;
    end else if (req1) begin
      winner = OWNER_M1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master Avalon-style arbiter in front of a single memory slave port; one transfer in flight.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin contention (default: fixed priority M0 > M1).
module mem_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,

  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,

  output logic [1:0]          grant
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  arb_state_t        state_reg, state_next;
  logic              last_owner_reg, last_owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  logic req0, req1;
  logic done0, done1;
  logic winner;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign done0 = (state_reg == OWN0) & req0 & ~s_waitrequest;
  assign done1 = (state_reg == OWN1) & req1 & ~s_waitrequest;

  always_comb begin
    hold_cnt_next = hold_cnt_reg;
`ifdef ARB_ROUND_ROBIN_EN
    hold_cnt_next = '0;
`else
    if (!req1 || state_reg == OWN1) begin
      hold_cnt_next = '0;
    end else if (done0 && hold_cnt_reg != HOLD_W'(HOLD_MAX)) begin
      hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
    end
`endif
  end

  // Arbitrate on the post-update count so the completion that reaches HOLD_MAX hands over immediately.
  arb_policy #(
    .HOLD_MAX (HOLD_MAX),
    .HOLD_W   (HOLD_W)
  ) u_policy (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_reg),
    .hold_cnt   (hold_cnt_next),
    .winner     (winner)
  );

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          state_next = own_state(winner);
        end
      end
      OWN0: begin
        if (done0) begin
          state_next = (req0 || req1) ? own_state(winner) : IDLE;
        end else if (!req0) begin
          state_next = IDLE;
        end
      end
      OWN1: begin
        if (done1) begin
          state_next = (req0 || req1) ? own_state(winner) : IDLE;
        end else if (!req1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == OWN0) begin
      last_owner_next = OWNER_M0;
    end else if (state_next == OWN1) begin
      last_owner_next = OWNER_M1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= OWNER_M1;
      hold_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

  // Slave side follows the registered owner so an async reset drops read/write at once.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_reg)
      OWN0: begin
        s_address      = m0_address;
        s_write        = m0_write;
        s_read         = m0_read & ~m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      OWN1: begin
        s_address      = m1_address;
        s_write        = m1_write;
        s_read         = m1_read & ~m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign grant       = grant_of(state_reg);
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; contention steps adapt to the ARB_ROUND_ROBIN_EN build option.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  grant;

  int n_vec  = 0;
  int n_fail = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .HOLD_MAX(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .grant          (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Packed idle view: {grant, s_read, s_write, m0_waitrequest, m1_waitrequest}
  function automatic logic [31:0] idle_view();
    return {26'd0, grant, s_read, s_write, m0_waitrequest, m1_waitrequest};
  endfunction

  initial begin
    reset = 1'b0;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b1;
    s_readdata = 32'hDEAD_BEEF;

    step(); step();
    #1 check("reset_idle", idle_view(), 32'h03);
    reset = 1'b1;

    // 1: idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      #1 check("idle_cycle", idle_view(), 32'h03);
    end

    // 2: M0 read, slave stalls 2 cycles
    m0_read = 1'b1; m0_address = 32'h0000_1000;
    #1 check("m0rd_latency_grant", {30'd0, grant}, 32'h0);
    check("m0rd_latency_sread", {31'd0, s_read}, 32'h0);
    step();
    #1 check("m0rd_c1_addr", s_address, 32'h0000_1000);
    check("m0rd_c1_grant", {30'd0, grant}, 32'h1);
    check("m0rd_c1_sread", {31'd0, s_read}, 32'h1);
    check("m0rd_c1_wait", {31'd0, m0_waitrequest}, 32'h1);
    step();
    #1 check("m0rd_c2_wait", {31'd0, m0_waitrequest}, 32'h1);
    step();
    s_waitrequest = 1'b0;
    #1 check("m0rd_c3_wait", {31'd0, m0_waitrequest}, 32'h0);
    check("m0rd_c3_rdata", m0_readdata, 32'hDEAD_BEEF);
    check("m0rd_c3_m1wait", {31'd0, m1_waitrequest}, 32'h1);
    step();
    m0_read = 1'b0; s_waitrequest = 1'b1;
    #1 check("m0rd_drop_sread", {31'd0, s_read}, 32'h0);
    step();
    #1 check("m0rd_abandon_idle", idle_view(), 32'h03);

    // 3: simultaneous requests
    m0_write = 1'b1; m0_address = 32'h2000; m0_writedata = 32'h1111_1111; m0_byteenable = 4'hF;
    m1_read = 1'b1; m1_address = 32'h3000;
    step();
    #1 check("cont_first_grant", {30'd0, grant}, 32'h1);
    check("cont_first_addr", s_address, 32'h2000);
    check("cont_first_swrite", {31'd0, s_write}, 32'h1);
    check("cont_first_m1wait", {31'd0, m1_waitrequest}, 32'h1);
    s_waitrequest = 1'b0;
    #1 check("cont_m0_done", {31'd0, m0_waitrequest}, 32'h0);
    step();
    m0_write = 1'b0; s_waitrequest = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    #1 check("cont_rr_second_grant", {30'd0, grant}, 32'h2);
`else
    #1 check("cont_fp_regrant_m0", {30'd0, grant}, 32'h1);
    step();
    #1 check("cont_fp_abandon", {30'd0, grant}, 32'h0);
    step();
    #1 check("cont_fp_m1_grant", {30'd0, grant}, 32'h2);
`endif
    check("cont_m1_addr", s_address, 32'h3000);
    check("cont_m1_sread", {31'd0, s_read}, 32'h1);
    s_waitrequest = 1'b0;
    #1 check("cont_m1_done", {31'd0, m1_waitrequest}, 32'h0);
    check("cont_m1_rdata", m1_readdata, 32'hDEAD_BEEF);
    step();
    m1_read = 1'b0; s_waitrequest = 1'b1;
    step();
    #1 check("cont_back_idle", idle_view(), 32'h03);

`ifndef ARB_ROUND_ROBIN_EN
    // 4: M0 streams zero-wait writes while M1 read waits; M1 gets in after the 4th
    m0_write = 1'b1; m0_address = 32'h0000_0100; m0_writedata = 32'hA000_0000;
    m1_read = 1'b1; m1_address = 32'h4000;
    s_waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      m0_writedata = 32'hA000_0000 + k;
      #1 check("hold_m0_grant", {30'd0, grant}, 32'h1);
      check("hold_m0_wdata", s_writedata, 32'hA000_0000 + k);
      check("hold_m1_wait", {31'd0, m1_waitrequest}, 32'h1);
    end
    step();
    #1 check("hold_m1_grant", {30'd0, grant}, 32'h2);
    check("hold_m1_addr", s_address, 32'h4000);
    check("hold_m1_done", {31'd0, m1_waitrequest}, 32'h0);
    step();
    m0_write = 1'b0; m1_read = 1'b0; s_waitrequest = 1'b1;
    #1 check("hold_regrant_m0", {30'd0, grant}, 32'h1);
    step();
    #1 check("hold_back_idle", idle_view(), 32'h03);
`endif

    // 6: M1 read and write together -> write wins
    m1_read = 1'b1; m1_write = 1'b1; m1_address = 32'h5000;
    m1_writedata = 32'h1234_5678; m1_byteenable = 4'h3;
    step();
    #1 check("rw_swrite", {31'd0, s_write}, 32'h1);
    check("rw_sread", {31'd0, s_read}, 32'h0);
    check("rw_be", {28'd0, s_byteenable}, 32'h3);
    check("rw_wdata", s_writedata, 32'h1234_5678);
    s_waitrequest = 1'b0;
    step();
    m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = 4'h0; s_waitrequest = 1'b1;
    step();
    #1 check("rw_back_idle", idle_view(), 32'h03);

    // 5: async reset in the middle of an M1 read
    m1_read = 1'b1; m1_address = 32'h6000;
    step();
    #1 check("rst_pre_sread", {31'd0, s_read}, 32'h1);
    check("rst_pre_grant", {30'd0, grant}, 32'h2);
    #3 reset = 1'b0;
    #1 check("rst_mid_sread", {31'd0, s_read}, 32'h0);
    check("rst_mid_grant", {30'd0, grant}, 32'h0);
    check("rst_mid_m1wait", {31'd0, m1_waitrequest}, 32'h1);
    m1_read = 1'b0;
    step();
    reset = 1'b1;
    step();
    #1 check("rst_after_idle", idle_view(), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
